// File: rtl/latency_credit_fifo.sv
// Credit-gated first-word-fall-through FIFO behind a fixed-latency delay line.
// Optional feature macro: LATENCY_CREDIT_FIFO_BYPASS_EN (same-cycle bypass when empty).
module latency_credit_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  output logic                  credit_ok,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  credits,
  output logic                  ovf_err,
  output logic                  crd_err
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  credits_q, credits_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  crd_err_q, crd_err_d;
  logic                  empty_s, full_s, pop_s, push_s, byp_s, issue_acc_s;

  // Next-state for pointers, occupancy, credits and sticky flags.
  always_comb begin
    empty_s     = (count_q == CNT_WIDTH'(0));
    full_s      = (count_q == CNT_WIDTH'(DEPTH));
    pop_s       = !empty_s && out_ready;
`ifdef LATENCY_CREDIT_FIFO_BYPASS_EN
    byp_s       = empty_s && in_valid && out_ready;
`else
    byp_s       = 1'b0;
`endif
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    push_s      = in_valid && !byp_s && (!full_s || pop_s);
    issue_acc_s = issue && (credits_q != CNT_WIDTH'(0));

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d   = count_q + CNT_WIDTH'(push_s) - CNT_WIDTH'(pop_s);
    credits_d = credits_q - CNT_WIDTH'(issue_acc_s) + CNT_WIDTH'(pop_s) + CNT_WIDTH'(byp_s);
    ovf_err_d = ovf_err_q || (in_valid && full_s && !pop_s);
    crd_err_d = crd_err_q || (issue && !issue_acc_s);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= PTR_WIDTH'(0);
      rd_ptr_q  <= PTR_WIDTH'(0);
      count_q   <= CNT_WIDTH'(0);
      credits_q <= CNT_WIDTH'(DEPTH);
      ovf_err_q <= 1'b0;
      crd_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      ovf_err_q <= ovf_err_d;
      crd_err_q <= crd_err_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign credit_ok = (credits_q != CNT_WIDTH'(0));
  assign count     = count_q;
  assign credits   = credits_q;
  assign ovf_err   = ovf_err_q;
  assign crd_err   = crd_err_q;

`ifdef LATENCY_CREDIT_FIFO_BYPASS_EN
  assign out_valid = !empty_s || in_valid;
  assign out_data  = empty_s ? in_data : mem_q[rd_ptr_q];
`else
  assign out_valid = !empty_s;
  assign out_data  = mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_latency_credit_fifo.sv
// Randomized bench for latency_credit_fifo: a 5-cycle delay line feeds the DUT, and a
// queue-based model of the FIFO/credit rules is compared against the DUT every cycle.
module tb_latency_credit_fifo;
  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int LAT   = 5;
`ifdef LATENCY_CREDIT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, issue, credit_ok, in_valid, out_valid, out_ready, ovf_err, crd_err;
  logic [DW-1:0] in_data, out_data;
  logic [3:0]    count, credits;

  always #5 clk = ~clk;

  latency_credit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .issue(issue), .credit_ok(credit_ok),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .credits(credits), .ovf_err(ovf_err), .crd_err(crd_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  int            m_cred = DEPTH;
  bit            m_ovf, m_crd, m_byp, m_pop;

  bit            dlv [LAT];
  logic [DW-1:0] dld [LAT];
  bit            frc, fv;
  logic [DW-1:0] fd, iss_data;
  bit            chk_en = 1'b0;
  bit            inv_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int inflight();
    int n = 0;
    for (int i = 0; i < LAT; i++) n += int'(dlv[i]);
    return n;
  endfunction

  // Reference model: queue of stored words plus a credit counter.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cred = DEPTH;
      m_ovf  = 1'b0;
      m_crd  = 1'b0;
    end else begin
      m_byp = BYP && (mq.size() == 0) && in_valid && out_ready;
      m_pop = (mq.size() != 0) && out_ready;
      if (issue) begin
        if (m_cred > 0) m_cred--;
        else m_crd = 1'b1;
      end
      if (m_pop) begin
        void'(mq.pop_front());
        m_cred++;
      end
      if (m_byp) m_cred++;
      else if (in_valid) begin
        if (mq.size() < DEPTH) mq.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // Cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = (mq.size() != 0) || (BYP && in_valid);
      chk("count", int'(count), mq.size());
      chk("credits", int'(credits), m_cred);
      chk("credit_ok", int'(credit_ok), int'(m_cred != 0));
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev) chk("out_data", int'(out_data), int'((mq.size() != 0) ? mq[0] : in_data));
      chk("ovf_err", int'(ovf_err), int'(m_ovf));
      chk("crd_err", int'(crd_err), int'(m_crd));
      if (inv_en) chk("invariant", int'(credits) + int'(count) + inflight(), DEPTH);
    end
  end

  task automatic apply_in();
    if (frc) begin
      in_valid = fv;
      in_data  = fd;
    end else begin
      in_valid = dlv[LAT-1];
      in_data  = dld[LAT-1];
    end
  endtask

  // One clock: DUT/model consume inputs, then the delay line shifts.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < LAT; i++) dlv[i] = 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        dlv[i] = dlv[i-1];
        dld[i] = dld[i-1];
      end
      dlv[0] = issue;
      dld[0] = iss_data;
      if (issue) iss_data = iss_data + 12'h001;
    end
    apply_in();
  endtask

  task automatic cyc(input bit want, input bit rdy);
    issue     = want && (m_cred != 0);
    out_ready = rdy;
    tick();
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; out_ready = 1'b0;
    frc = 1'b0; fv = 1'b0; fd = 12'h000; iss_data = 12'h001;
    for (int i = 0; i < LAT; i++) begin
      dlv[i] = 1'b0;
      dld[i] = 12'h000;
    end
    apply_in();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    inv_en = 1'b1;

    // Reset and idle.
    repeat (3) cyc(1'b0, 1'b0);
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_credits", int'(credits), 8);
    chk("rst_credit_ok", int'(credit_ok), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_flags", int'({ovf_err, crd_err}), 0);

    // Fill with 0x001..0x008 while the consumer stalls.
    iss_data = 12'h001;
    repeat (8) cyc(1'b1, 1'b0);
    #2;
    chk("fill_credit_ok", int'(credit_ok), 0);
    repeat (LAT) cyc(1'b0, 1'b0);
    #2;
    chk("fill_count", int'(count), 8);
    chk("fill_credits", int'(credits), 0);
    chk("fill_head", int'(out_data), 12'h001);
    chk("fill_flags", int'({ovf_err, crd_err}), 0);

    // Drain in order.
    issue = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("drain_data", int'(out_data), i + 1);
      tick();
    end
    #2;
    chk("drain_count", int'(count), 0);
    chk("drain_credits", int'(credits), 8);
    chk("drain_out_valid", int'(out_valid), 0);

    // Steady stream, 40 words, pointers wrap five times.
    iss_data = 12'h100;
    repeat (40) cyc(1'b1, 1'b1);
    repeat (LAT + 1) cyc(1'b0, 1'b1);
    #2;
    chk("stream_count", int'(count), 0);
    chk("stream_credits", int'(credits), 8);

    // Error flags: issue with no credit, push while full.
    repeat (8) cyc(1'b1, 1'b0);
    repeat (LAT) cyc(1'b0, 1'b0);
    inv_en = 1'b0;
    frc = 1'b1; fv = 1'b1; fd = 12'h3FF;
    issue = 1'b1; out_ready = 1'b0;
    apply_in();
    tick();
    frc = 1'b0;
    issue = 1'b0;
    apply_in();
    #2;
    chk("err_crd", int'(crd_err), 1);
    chk("err_ovf", int'(ovf_err), 1);
    chk("err_count", int'(count), 8);
    chk("err_credits", int'(credits), 0);
    repeat (2) cyc(1'b0, 1'b0);
    #2;
    chk("err_sticky", int'({ovf_err, crd_err}), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("err_cleared", int'({ovf_err, crd_err}), 0);
    chk("err_rst_credits", int'(credits), 8);
    inv_en = 1'b1;

    // Single word 0xABC into an empty FIFO with the consumer ready.
    iss_data = 12'hABC;
    cyc(1'b1, 1'b1);
    repeat (LAT - 1) cyc(1'b0, 1'b1);
    #2;
    chk("abc_in_valid", int'(in_valid), 1);
    chk("abc_same_valid", int'(out_valid), int'(BYP));
    chk("abc_same_data", int'(out_valid ? out_data : 12'hABC), 12'hABC);
    cyc(1'b0, 1'b1);
    #2;
    chk("abc_next_valid", int'(out_valid), int'(!BYP));
    chk("abc_next_data", int'(out_valid ? out_data : 12'hABC), 12'hABC);
    chk("abc_next_count", int'(count), int'(!BYP));
    cyc(1'b0, 1'b1);
    #2;
    chk("abc_end_count", int'(count), 0);
    chk("abc_end_credits", int'(credits), 8);

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    repeat (20) cyc(1'b0, 1'b1);
    #2;
    chk("final_count", int'(count), 0);
    chk("final_credits", int'(credits), 8);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
